// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer behind an SPI byte slave: turns SSEL-framed command/data
// bytes into auto-incrementing register reads and writes and feeds transmit bytes back.
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  DUMMY  = 8'hA5
) (
  input  logic              clk,
  input  logic              PRESET,
  input  logic              SSEL,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  input  logic              err_clr,
  output logic              err,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              ssel_meta_q, ssel_sync_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_load_q, tx_load_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              cmd_bad;
  logic              wr_en, rd_en;
  logic [7:0]        wdata;

  // Any command address bit above the bank's range makes the command invalid;
  // the shift form stays legal even when ADDR_W covers all seven address bits.
  assign cmd_bad = ((rx_byte[6:0] >> ADDR_W) != 7'd0);

  always_ff @(posedge clk) begin
    if (PRESET) begin
      state_q      <= S_IDLE;
      ssel_meta_q  <= 1'b1;
      ssel_sync_q  <= 1'b1;
      addr_q       <= '0;
      tx_byte_q    <= '0;
      tx_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ssel_meta_q  <= SSEL;
      ssel_sync_q  <= ssel_meta_q;
      addr_q       <= addr_d;
      tx_byte_q    <= tx_byte_d;
      tx_load_q    <= tx_load_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tx_byte_d    = tx_byte_q;
    tx_load_d    = 1'b0;
    frame_done_d = 1'b0;
    err_set      = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    wdata        = '0;

    // Deselect outranks everything, including a byte completing in the same cycle.
    if (state_q != S_IDLE && ssel_sync_q) begin
      state_d      = S_IDLE;
      frame_done_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!ssel_sync_q) begin
            state_d   = S_CMD;
            tx_byte_d = DUMMY;
            tx_load_d = 1'b1;
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            if (cmd_bad) begin
              err_set = 1'b1;
              state_d = S_DRAIN;
            end else begin
              addr_d  = rx_byte[ADDR_W-1:0];
              state_d = rx_byte[7] ? S_RD_REQ : S_WR;
            end
          end
        end
        S_WR: begin
          if (rx_valid) begin
            wr_en  = 1'b1;
            wdata  = rx_byte;
            addr_d = addr_q + 1'b1;
          end
        end
        S_RD_REQ: begin
          rd_en   = 1'b1;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          tx_byte_d = reg_rdata;
          tx_load_d = 1'b1;
          addr_d    = addr_q + 1'b1;
          state_d   = S_RD_HOLD;
        end
        S_RD_HOLD: begin
          // The master's byte is ignored; it only paces the next prefetch.
          if (rx_valid) begin
            state_d = S_RD_REQ;
          end
        end
        S_DRAIN: begin
          state_d = S_DRAIN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    err_d = err_set | (err_q & ~err_clr);
  end

  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata;
  assign reg_wr_en  = wr_en;
  assign reg_rd_en  = rd_en;
  assign err        = err_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
